// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder: accepts one load/store, waits
// LATENCY cycles, then commits to the word array and holds the response until taken.
module dmem_resp #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] err_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [2:0]  LAT     = 3'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          we_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH];

  logic accept;
  logic commit;
  logic handshake;
  logic req_err;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  // The first edge spent in RESP with no response yet is the commit edge.
  assign commit    = (state == RESP) & ~rsp_valid;
  assign handshake = (state == RESP) & rsp_valid & rsp_ready;
  assign req_err   = (req_addr[1:0] != 2'b00) | (req_addr[31:2] >= DEPTH_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (LAT == 3'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (handshake) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 3'd0;
    end else if (accept) begin
      cnt <= LAT;
    end else if (state == WAIT) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Request fields are frozen at accept so later input changes cannot leak in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
      be_q    <= req_be;
      we_q    <= req_we;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      err_cnt   <= 16'h0;
    end else if (commit) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err_q;
      rsp_rdata <= (!we_q && !err_q) ? mem[idx_q] : 32'h0;
      if (err_q && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'h1;
      end
    end else if (handshake) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end
  end

  // Storage is deliberately not reset; a dropped transaction never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the internal array; power of two, 4..1024.
REQ-002 Parameter LATENCY, default 2: wait states per access; legal range 0..7.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the name follows the codebase, the polarity is active-low.
REQ-005 req_valid  input  1  core presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i selects wdata[8i+7:8i]; ignored on loads.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  core accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.
REQ-015 err_cnt  output  16  count of error responses; saturates at 0xFFFF.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and RESP; one transaction is outstanding at most.
REQ-017 req_ready SHALL be 1 in IDLE and 0 in WAIT and RESP; it is decoded from state only.
REQ-018 Accept = req_valid & req_ready at an edge T0; addr, wdata, be and we SHALL be captured at T0, and later input changes SHALL have no effect.
REQ-019 Error at accept SHALL be addr[1:0] != 0, or addr[31:2] >= DEPTH.
REQ-020 At T0 the FSM SHALL go to WAIT and load a 3-bit counter with LATENCY; if LATENCY = 0 it SHALL go directly to RESP.
REQ-021 In WAIT the counter SHALL decrement each edge; at the edge where it equals 1 the FSM SHALL go to RESP.
REQ-022 rsp_valid SHALL rise at edge T0+1+LATENCY, called the commit edge.
REQ-023 At the commit edge of an error-free store, the array SHALL write the enabled bytes only, and rsp_rdata SHALL load 0.
REQ-024 At the commit edge of an error-free load, rsp_rdata SHALL load array[addr[31:2]] as it was before that edge.
REQ-025 At the commit edge of an errored request, the array SHALL NOT be written, rsp_rdata SHALL load 0, rsp_err SHALL load 1, and err_cnt SHALL increment (saturating at 0xFFFF).
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready = 1.
REQ-027 At the edge where rsp_valid & rsp_ready: FSM goes to IDLE, rsp_valid, rsp_err and rsp_rdata clear to 0, and req_ready = 1 in the following cycle.
REQ-028 A new request SHALL NOT be accepted at the response-handshake edge; minimum spacing between accepts is LATENCY+3 cycles.
REQ-029 req_be = 0 on a store SHALL complete normally without modifying the array.
REQ-030 rsp_ready asserted while rsp_valid = 0 SHALL be ignored.

Reset
REQ-031 While reset = 0: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_cnt = 0, and req_ready = 1 once reset is released.
REQ-032 Reset asserted before the commit edge SHALL drop the transaction with no array write; reset asserted in RESP SHALL discard the response.
REQ-033 Array contents SHALL NOT be reset; a load of an unwritten word returns an undefined value.

Verification
REQ-034 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF accepted at T0, then load 0x10 -> load rsp_valid at T0'+3 with rdata 0xDEADBEEF, err 0.
REQ-035 Store 0x11223344 with be 0xF, then store 0xAABBCCDD with be 0x5 to the same address, then load -> rdata 0x11BB33DD.
REQ-036 Load addr 0x2 and load addr DEPTH*4 -> each has rsp_err 1 and rdata 0; err_cnt ends at 2; array is unchanged.
REQ-037 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable and req_ready stays 0; after the handshake, req_ready = 1 on the next cycle.
REQ-038 LATENCY=0: accept at T0 -> rsp_valid at T0+1; with rsp_ready tied to 1, accepts are spaced every 3 cycles.
REQ-039 Store accepted, then reset pulsed low in WAIT -> outputs return to reset values and a later load of that address does not return the store data.
